// File: rtl/syn_io_resp.sv
// Responder for the synapse-array op interface: accepts one op per start and
// sequences precharge, wordline/sense/write and correlation-reset strobes.
module syn_io_resp #(
    parameter int ROW_W    = 5,
    parameter int COLSET_W = 2,
    parameter int DATA_W   = 128,
    parameter int T_PC     = 2,
    parameter int T_RD     = 4,
    parameter int T_WR     = 6,
    parameter int T_RST    = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [3:0]          opcd,
    input  logic [ROW_W-1:0]    row,
    input  logic [COLSET_W-1:0] colset,
    input  logic [DATA_W-1:0]   wdata,
    output logic                busy,
    output logic [DATA_W-1:0]   rdata,
    output logic                rdata_valid,
    output logic                err,
    output logic [ROW_W-1:0]    arr_row,
    output logic [COLSET_W-1:0] arr_colset,
    output logic                arr_pc,
    output logic                arr_wl,
    output logic                arr_sense,
    output logic                arr_we,
    output logic                arr_rst_corr,
    output logic [DATA_W-1:0]   arr_din,
    input  logic [DATA_W-1:0]   arr_dout
);

    typedef enum logic [2:0] {S_IDLE, S_PC, S_RD, S_WR, S_RST} state_t;

    localparam logic [3:0] OP_IDLE     = 4'd0;
    localparam logic [3:0] OP_READ     = 4'd1;
    localparam logic [3:0] OP_WRITE    = 4'd2;
    localparam logic [3:0] OP_RST_CORR = 4'd3;
    localparam logic [3:0] OP_READ_RST = 4'd4;

    localparam logic [3:0] PC_LD  = 4'(T_PC - 1);
    localparam logic [3:0] RD_LD  = 4'(T_RD - 1);
    localparam logic [3:0] WR_LD  = 4'(T_WR - 1);
    localparam logic [3:0] RST_LD = 4'(T_RST - 1);

    state_t     state, state_nx;
    logic [3:0] ctr, ctr_nx;
    logic [3:0] op_q;
    logic       accept, capture, done_read, err_nx;

    always_comb begin
        state_nx  = state;
        ctr_nx    = ctr;
        accept    = 1'b0;
        capture   = 1'b0;
        done_read = 1'b0;
        err_nx    = start && ((state != S_IDLE) || (opcd > OP_READ_RST));
        case (state)
            S_IDLE: begin
                if (start && (opcd != OP_IDLE) && (opcd <= OP_READ_RST)) begin
                    accept = 1'b1;
                    if (opcd == OP_RST_CORR) begin
                        state_nx = S_RST;
                        ctr_nx   = RST_LD;
                    end else begin
                        state_nx = S_PC;
                        ctr_nx   = PC_LD;
                    end
                end
            end
            S_PC: begin
                if (ctr == 4'd0) begin
                    if (op_q == OP_WRITE) begin
                        state_nx = S_WR;
                        ctr_nx   = WR_LD;
                    end else begin
                        state_nx = S_RD;
                        ctr_nx   = RD_LD;
                    end
                end else begin
                    ctr_nx = ctr - 4'd1;
                end
            end
            S_RD: begin
                if (ctr == 4'd0) begin
                    capture = 1'b1;
                    // READ_RST chains into the correlation reset without a second precharge
                    if (op_q == OP_READ_RST) begin
                        state_nx = S_RST;
                        ctr_nx   = RST_LD;
                    end else begin
                        state_nx  = S_IDLE;
                        done_read = 1'b1;
                    end
                end else begin
                    ctr_nx = ctr - 4'd1;
                end
            end
            S_WR: begin
                if (ctr == 4'd0) begin
                    state_nx = S_IDLE;
                end else begin
                    ctr_nx = ctr - 4'd1;
                end
            end
            S_RST: begin
                if (ctr == 4'd0) begin
                    state_nx  = S_IDLE;
                    done_read = (op_q == OP_READ_RST);
                end else begin
                    ctr_nx = ctr - 4'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                ctr_nx   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            ctr   <= 4'd0;
            op_q  <= OP_IDLE;
        end else begin
            state <= state_nx;
            ctr   <= ctr_nx;
            if (accept) begin
                op_q <= opcd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arr_row    <= '0;
            arr_colset <= '0;
            arr_din    <= '0;
        end else if (accept) begin
            arr_row    <= row;
            arr_colset <= colset;
            arr_din    <= wdata;
        end
    end

    // Strobes and busy are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy         <= 1'b0;
            arr_pc       <= 1'b0;
            arr_wl       <= 1'b0;
            arr_sense    <= 1'b0;
            arr_we       <= 1'b0;
            arr_rst_corr <= 1'b0;
            err          <= 1'b0;
            rdata_valid  <= 1'b0;
            rdata        <= '0;
        end else begin
            busy         <= (state_nx != S_IDLE);
            arr_pc       <= (state_nx == S_PC);
            arr_wl       <= (state_nx == S_RD) || (state_nx == S_WR) || (state_nx == S_RST);
            arr_sense    <= (state_nx == S_RD);
            arr_we       <= (state_nx == S_WR);
            arr_rst_corr <= (state_nx == S_RST);
            err          <= err_nx;
            rdata_valid  <= done_read;
            if (capture) begin
                rdata <= arr_dout;
            end
        end
    end

endmodule
